// File: rtl/msgpu_commands_pkg.sv
// Shared command codes, default device ID, address width and sequencer state
// type for the MCU parallel-bus command path.
package msgpu_commands_pkg;

   localparam logic [7:0] CMD_NOP         = 8'h00;
   localparam logic [7:0] CMD_GET_ID      = 8'h01;
   localparam logic [7:0] CMD_SET_ADDRESS = 8'h02;
   localparam logic [7:0] CMD_WRITE_DATA  = 8'h03;
   localparam logic [7:0] CMD_READ_DATA   = 8'h04;

   localparam logic [7:0]  DEFAULT_DEVICE_ID = 8'hAE;
   localparam int unsigned DEFAULT_ADDR_W    = 19;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_SEND_ID    = 3'd1,
      S_ADDR       = 3'd2,
      S_WRITE      = 3'd3,
      S_WRITE_WAIT = 3'd4,
      S_READ       = 3'd5,
      S_READ_WAIT  = 3'd6
   } seq_state_t;

   // A memory request is outstanding in exactly these states.
   function automatic logic is_wait_state(input seq_state_t s);
      return (s == S_WRITE_WAIT) || (s == S_READ_WAIT);
   endfunction

endpackage

// File: rtl/mcu_seq_addr_counter.sv
// Framebuffer address register: 4-byte MSB-first shadow load that commits
// only on the last byte, plus post-access increment wrapping modulo 2**ADDR_W.
module mcu_seq_addr_counter
   import msgpu_commands_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_start,
   input  logic              load_en,
   input  logic [7:0]        load_byte,
   input  logic              incr,
   output logic              load_last,
   output logic [ADDR_W-1:0] addr
);

   logic [23:0] shadow;
   logic [1:0]  byte_cnt;
   logic [31:0] load_word;
   logic        unused_load_hi;

   // Full 32-bit word as it stands once the current byte is shifted in.
   always_comb begin
      load_word = {shadow, load_byte};
   end

   assign load_last      = (byte_cnt == 2'd3);
   assign unused_load_hi = ^load_word;

   // Shadow shift/commit and address increment.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shadow   <= '0;
         byte_cnt <= '0;
         addr     <= '0;
      end else if (load_start) begin
         shadow   <= '0;
         byte_cnt <= '0;
      end else if (load_en) begin
         shadow <= load_word[23:0];
         if (load_last) begin
            addr     <= load_word[ADDR_W-1:0];
            byte_cnt <= '0;
         end else begin
            byte_cnt <= byte_cnt + 2'd1;
         end
      end else if (incr) begin
         addr <= addr + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/mcu_command_sequencer.sv
// Command/state controller behind the MCU parallel bus front-end: decodes
// command strobes, sequences the address load and the auto-incrementing
// framebuffer port, and returns response bytes.
// Optional feature macro: MCU_SEQ_READ_EN (READ_DATA command and read path).
module mcu_command_sequencer
   import msgpu_commands_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
   parameter logic [7:0]  DEVICE_ID = DEFAULT_DEVICE_ID
) (
   input  logic              system_clock,
   input  logic              reset_n,
   input  logic              cmd_strobe,
   input  logic [7:0]        cmd_byte,
   input  logic              data_strobe,
   input  logic [7:0]        data_byte,
   output logic              busy,
   output logic              resp_valid,
   output logic [7:0]        resp_data,
   output logic              error,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic              mem_ready,
   input  logic [7:0]        mem_rdata
);

   seq_state_t state;
   logic       cmd_accept;
   logic       load_start;
   logic       load_en;
   logic       addr_incr;
   logic       load_last;

   assign busy = is_wait_state(state);

   // Commands are refused while an access is outstanding; the access finishes first.
   always_comb begin
      cmd_accept = cmd_strobe && !busy;
      load_start = cmd_accept && (cmd_byte == CMD_SET_ADDRESS);
      load_en    = !cmd_strobe && data_strobe && (state == S_ADDR);
      addr_incr  = busy && mem_ready;
   end

   mcu_seq_addr_counter #(
      .ADDR_W (ADDR_W)
   ) u_addr (
      .clk        (system_clock),
      .reset_n    (reset_n),
      .load_start (load_start),
      .load_en    (load_en),
      .load_byte  (data_byte),
      .incr       (addr_incr),
      .load_last  (load_last),
      .addr       (mem_addr)
   );

`ifndef MCU_SEQ_READ_EN
   logic unused_rdata;
   assign mem_read     = 1'b0;
   assign unused_rdata = ^mem_rdata;
`endif

   // Main FSM: command decode, address-load ack, ID response and memory handshake.
   always_ff @(posedge system_clock) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         error      <= 1'b0;
         mem_wdata  <= '0;
         mem_write  <= 1'b0;
`ifdef MCU_SEQ_READ_EN
         mem_read   <= 1'b0;
`endif
      end else begin
         resp_valid <= 1'b0;
         error      <= 1'b0;
         if (cmd_accept) begin
            // A data byte arriving alongside a command is dropped.
            error <= data_strobe;
            case (cmd_byte)
               CMD_NOP:         state <= S_IDLE;
               CMD_GET_ID:      state <= S_SEND_ID;
               CMD_SET_ADDRESS: state <= S_ADDR;
               CMD_WRITE_DATA:  state <= S_WRITE;
`ifdef MCU_SEQ_READ_EN
               CMD_READ_DATA:   state <= S_READ;
`endif
               default: begin
                  error <= 1'b1;
                  state <= S_IDLE;
               end
            endcase
         end else begin
            case (state)
               S_IDLE: begin
                  error <= data_strobe;
               end
               S_SEND_ID: begin
                  resp_valid <= 1'b1;
                  resp_data  <= DEVICE_ID;
                  error      <= data_strobe;
                  state      <= S_IDLE;
               end
               S_ADDR: begin
                  if (data_strobe && load_last) begin
                     resp_valid <= 1'b1;
                     resp_data  <= CMD_SET_ADDRESS;
                     state      <= S_IDLE;
                  end
               end
               S_WRITE: begin
                  if (data_strobe) begin
                     mem_write <= 1'b1;
                     mem_wdata <= data_byte;
                     state     <= S_WRITE_WAIT;
                  end
               end
               S_WRITE_WAIT: begin
                  error <= cmd_strobe || data_strobe;
                  if (mem_ready) begin
                     mem_write <= 1'b0;
                     state     <= S_WRITE;
                  end
               end
`ifdef MCU_SEQ_READ_EN
               S_READ: begin
                  if (data_strobe) begin
                     mem_read <= 1'b1;
                     state    <= S_READ_WAIT;
                  end
               end
               S_READ_WAIT: begin
                  error <= cmd_strobe || data_strobe;
                  if (mem_ready) begin
                     mem_read   <= 1'b0;
                     resp_valid <= 1'b1;
                     resp_data  <= mem_rdata;
                     state      <= S_READ;
                  end
               end
`endif
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mcu_command_sequencer.sv
// Self-checking bench for mcu_command_sequencer: directed protocol steps plus
// randomized address/write/ID traffic against a queue-based memory model.
`timescale 1ns/1ps
module tb_mcu_command_sequencer;

   localparam int unsigned AW     = 19;
   localparam int unsigned ASPACE = 1 << AW;

   logic          system_clock = 1'b0;
   logic          reset_n, cmd_strobe, data_strobe, mem_ready;
   logic [7:0]    cmd_byte, data_byte, mem_rdata;
   logic          busy, resp_valid, error, mem_write, mem_read;
   logic [7:0]    resp_data, mem_wdata;
   logic [AW-1:0] mem_addr;

   int            tests = 0;
   int            fails = 0;
   int unsigned   model_addr = 0;
   int unsigned   lat = 0;
   bit            spurious = 1'b0;
   logic [7:0]    rd_value = 8'h00;
   int unsigned   req_age = 0;

   logic [AW-1:0] wlog_addr[$];
   logic [7:0]    wlog_data[$];
   int unsigned   exp_addr[$];
   logic [7:0]    exp_data[$];

   mcu_command_sequencer #(
      .ADDR_W    (19),
      .DEVICE_ID (8'hAE)
   ) dut (
      .system_clock (system_clock),
      .reset_n      (reset_n),
      .cmd_strobe   (cmd_strobe),
      .cmd_byte     (cmd_byte),
      .data_strobe  (data_strobe),
      .data_byte    (data_byte),
      .busy         (busy),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .error        (error),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_write    (mem_write),
      .mem_read     (mem_read),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata)
   );

   initial forever #5 system_clock = ~system_clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory responder: raises mem_ready `lat` cycles into a request and logs
   // every accepted write; optionally pulses mem_ready when nothing is pending.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(negedge system_clock);
         if (mem_write === 1'b1 || mem_read === 1'b1) begin
            if (req_age == lat) begin
               mem_ready = 1'b1;
               if (mem_write === 1'b1) begin
                  wlog_addr.push_back(mem_addr);
                  wlog_data.push_back(mem_wdata);
               end
               if (mem_read === 1'b1) mem_rdata = rd_value;
            end else begin
               mem_ready = 1'b0;
            end
            req_age++;
         end else begin
            req_age   = 0;
            mem_ready = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge system_clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [7:0] b);
      cmd_byte   = b;
      cmd_strobe = 1'b1;
      step();
      cmd_strobe = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] b);
      data_byte   = b;
      data_strobe = 1'b1;
      step();
      data_strobe = 1'b0;
   endtask

   task automatic id_tail(input string tag);
      check({tag, "_early"}, resp_valid, 0);
      step();
      check({tag, "_valid"}, resp_valid, 1);
      check({tag, "_data"}, resp_data, 8'hAE);
      step();
      check({tag, "_once"}, resp_valid, 0);
   endtask

   task automatic get_id(input string tag);
      send_cmd(8'h01);
      check({tag, "_err"}, error, 0);
      id_tail(tag);
   endtask

   task automatic set_addr(input string tag, input logic [31:0] val);
      logic [7:0] b;
      send_cmd(8'h02);
      check({tag, "_cmd_err"}, error, 0);
      for (int i = 0; i < 4; i++) begin
         b = 8'(val >> (24 - 8 * i));
         send_data(b);
         if (i < 3) begin
            check({tag, "_hold"}, mem_addr, model_addr);
            check({tag, "_noack"}, resp_valid, 0);
         end
      end
      model_addr = val & (ASPACE - 1);
      check({tag, "_addr"}, mem_addr, model_addr);
      check({tag, "_ack_v"}, resp_valid, 1);
      check({tag, "_ack_d"}, resp_data, 8'h02);
      step();
      check({tag, "_ack_once"}, resp_valid, 0);
   endtask

   task automatic wait_idle(input string tag);
      int unsigned n = 0;
      while (busy === 1'b1 && n < 20) begin
         check({tag, "_held"}, {31'd0, mem_write | mem_read}, 1);
         step();
         n++;
      end
      check({tag, "_done"}, busy, 0);
   endtask

   task automatic write_byte(input string tag, input logic [7:0] d);
      exp_addr.push_back(model_addr);
      exp_data.push_back(d);
      model_addr = (model_addr + 1) % ASPACE;
      send_data(d);
      check({tag, "_err"}, error, 0);
      wait_idle(tag);
      check({tag, "_next"}, mem_addr, model_addr);
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_count"}, wlog_addr.size(), exp_addr.size());
      while (wlog_addr.size() > 0 && exp_addr.size() > 0) begin
         check({tag, "_waddr"}, wlog_addr.pop_front(), exp_addr.pop_front());
         check({tag, "_wdata"}, wlog_data.pop_front(), exp_data.pop_front());
      end
      wlog_addr.delete();
      wlog_data.delete();
      exp_addr.delete();
      exp_data.delete();
   endtask

   task automatic bad_cmd(input string tag, input logic [7:0] code);
      send_cmd(code);
      check({tag, "_err"}, error, 1);
      check({tag, "_resp"}, resp_valid, 0);
      step();
      check({tag, "_err_once"}, error, 0);
      check({tag, "_addr"}, mem_addr, model_addr);
   endtask

   initial begin
      logic [31:0] v;
      logic [7:0]  d;
      int unsigned n;
      reset_n     = 1'b0;
      cmd_strobe  = 1'b0;
      data_strobe = 1'b0;
      cmd_byte    = 8'h00;
      data_byte   = 8'h00;

      // Reset state
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_resp", resp_valid, 0);
      check("rst_err", error, 0);
      check("rst_wr", mem_write, 0);
      check("rst_rd", mem_read, 0);
      check("rst_addr", mem_addr, 0);
      reset_n = 1'b1;
      step();

      // GET_ID timing and idle memory port
      get_id("id1");
      check("id1_wr", mem_write, 0);
      check("id1_rd", mem_read, 0);
      check("id1_addr", mem_addr, 0);

      // Address load, commit on the 4th byte
      set_addr("sa1", 32'h0000_1234);
      check("sa1_value", mem_addr, 19'h01234);

      // Wrap at the top of the address space
      set_addr("sa_top", 32'h0007_FFFF);
      send_cmd(8'h03);
      check("wr_cmd_err", error, 0);
      lat = 2;
      write_byte("wrapAA", 8'hAA);
      write_byte("wrap55", 8'h55);
      check("wrap_addr1", mem_addr, 1);
      check_writes("wrap");

      // Overrun while busy
      lat = 3;
      d = 8'($urandom);
      exp_addr.push_back(model_addr);
      exp_data.push_back(d);
      model_addr = (model_addr + 1) % ASPACE;
      send_data(d);
      check("ovr_busy", busy, 1);
      send_data(8'hEE);
      check("ovr_err", error, 1);
      wait_idle("ovr");
      check_writes("ovr_single");
      lat = 1;
      write_byte("ovr_next", 8'($urandom));
      check_writes("ovr_after");

      // Abort a partial address load with GET_ID
      v = $urandom;
      set_addr("ab_pre", v);
      send_cmd(8'h02);
      send_data(8'h12);
      send_data(8'h34);
      send_cmd(8'h01);
      check("ab_addr", mem_addr, model_addr);
      id_tail("ab_id");
      send_data(8'h99);
      check("idle_data_err", error, 1);

      // Simultaneous command and data strobes
      cmd_byte    = 8'h01;
      cmd_strobe  = 1'b1;
      data_byte   = 8'h66;
      data_strobe = 1'b1;
      step();
      cmd_strobe  = 1'b0;
      data_strobe = 1'b0;
      check("both_err", error, 1);
      id_tail("both_id");

      // Unknown command codes
      for (int i = 0; i < 4; i++) bad_cmd("unk", 8'($urandom_range(5, 255)));
`ifndef MCU_SEQ_READ_EN
      bad_cmd("rd_disabled", 8'h04);
`else
      set_addr("rd_pre", 32'h0000_0100);
      send_cmd(8'h04);
      rd_value = 8'h5A;
      lat = 1;
      send_data(8'h00);
      check("rd_busy", busy, 1);
      wait_idle("rd");
      check("rd_valid", resp_valid, 1);
      check("rd_data", resp_data, 8'h5A);
      check("rd_addr", mem_addr, 19'h00101);
      model_addr = 32'h101;
      step();
      check("rd_once", resp_valid, 0);
`endif

      // Reset during WRITE_WAIT abandons the access
      send_cmd(8'h03);
      lat = 3;
      send_data(8'h77);
      check("rw_busy", busy, 1);
      reset_n = 1'b0;
      step();
      check("rw_wr", mem_write, 0);
      check("rw_addr", mem_addr, 0);
      check("rw_busy0", busy, 0);
      reset_n = 1'b1;
      model_addr = 0;
      repeat (4) step();
      check_writes("rw_abandon");
      send_data(8'h11);
      check("rw_idle", error, 1);

      // Randomized traffic, with stray mem_ready pulses between requests
      spurious = 1'b1;
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               v = $urandom;
               if ($urandom_range(0, 1) == 1)
                  v = (v & 32'hFFF8_0000) | (ASPACE - 1 - $urandom_range(0, 2));
               set_addr("r_sa", v);
            end
            1: begin
               send_cmd(8'h03);
               check("r_wcmd_err", error, 0);
               n = $urandom_range(1, 4);
               for (int k = 0; k < int'(n); k++) begin
                  lat = $urandom_range(0, 3);
                  write_byte("r_wr", 8'($urandom));
                  repeat ($urandom_range(0, 2)) step();
               end
               check_writes("r_burst");
            end
            2: get_id("r_id");
            default: bad_cmd("r_unk", 8'($urandom_range(5, 255)));
         endcase
      end
      spurious = 1'b0;
      step();
      check("final_addr", mem_addr, model_addr);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
